odo_div_mon: RTL and testbench



---
 rtl/odo_div_pkg.sv | 21 ++
 rtl/odo_edge_sync.sv | 36 +++
 rtl/odo_div_mon.sv | 191 +++++++++++++++++++
 tb/tb_odo_div_mon.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/odo_div_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// Optional duty checking is enabled by defining ODO_MON_DUTY_CHK_EN.
package odo_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } odo_state_t;

    localparam int unsigned ODO_DIV_DEFAULT = 9;

    // An odd 50% divider holds the high phase for floor(div/2) or ceil(div/2) cycles.
    function automatic logic odo_hi_ok(input logic [15:0] hi, input logic [15:0] div);
        logic [15:0] lo_v;
        lo_v = (div - 16'd1) >> 1;
        return (hi == lo_v) || (hi == (lo_v + 16'd1));
    endfunction

endpackage

// File: rtl/odo_edge_sync.sv
// Two-flop synchronizer for the divided clock plus a third flop for rise detection.
// The synchronized level output exists only when ODO_MON_DUTY_CHK_EN is defined.
module odo_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
`ifdef ODO_MON_DUTY_CHK_EN
   ,output logic level
`endif
);

    logic s1;
    logic s2;
    logic s3;

    // synchronizer chain and delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

`ifdef ODO_MON_DUTY_CHK_EN
    assign level = s2;
`endif

endmodule

// File: rtl/odo_div_mon.sv
// Divided-clock monitor: measures period and high phase of every divided cycle,
// tracks lock and raises sticky faults. Duty checking is built with ODO_MON_DUTY_CHK_EN.
module odo_div_mon
    import odo_div_pkg::*;
#(
    parameter int unsigned DIV      = ODO_DIV_DEFAULT,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CW       = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_div_in,
    input  logic          clr_err,
    output logic          locked,
    output logic          period_err,
    output logic          duty_err,
    output logic          timeout_err,
    output logic [CW-1:0] last_period
);

    localparam logic [CW-1:0] PER_MAX = CW'(2 * DIV);
    localparam logic [CW-1:0] PER_TMO = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] DIV_W   = CW'(DIV);
    localparam logic [3:0]    LOCK_W  = 4'(LOCK_CNT);

    odo_state_t    state;
    logic [3:0]    good_cnt;
    logic [CW-1:0] per_cnt;
    logic [CW-1:0] per_meas;
    logic          rise;
    logic          hi_good;
    logic          per_good;
    logic          edge_good;
    logic          cmp_edge;
    logic          tmo;
    logic          per_set;

`ifdef ODO_MON_DUTY_CHK_EN
    logic          level;
    logic [CW-1:0] hi_cnt;
    logic          duty_set;

    odo_edge_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (clk_div_in),
        .rise  (rise),
        .level (level)
    );

    // high-phase counter; restarts at 1 because the edge cycle itself is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt <= {CW{1'b0}};
        end else if (rise) begin
            hi_cnt <= level ? CW'(1) : {CW{1'b0}};
        end else if (level && (hi_cnt != PER_MAX)) begin
            hi_cnt <= hi_cnt + CW'(1);
        end else begin
            hi_cnt <= hi_cnt;
        end
    end

    assign hi_good  = odo_hi_ok(16'(hi_cnt), 16'(DIV));
    assign duty_set = cmp_edge & ~hi_good;

    // sticky duty flag, a new error outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_err <= 1'b0;
        end else begin
            duty_err <= duty_set | (duty_err & ~clr_err);
        end
    end
`else
    odo_edge_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (clk_div_in),
        .rise (rise)
    );

    assign hi_good  = 1'b1;
    assign duty_err = 1'b0;
`endif

    assign per_meas  = per_cnt + CW'(1);
    assign per_good  = (per_meas == DIV_W);
    assign edge_good = per_good & hi_good;
    assign cmp_edge  = rise & ((state == ACQ) | (state == LOCKED));
    assign tmo       = ~rise & (state != IDLE) & (per_cnt == PER_TMO);
    assign per_set   = cmp_edge & ~per_good;

    // period counter saturates so a lost divided clock holds at the timeout value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt     <= {CW{1'b0}};
            last_period <= {CW{1'b0}};
        end else if (rise) begin
            per_cnt     <= {CW{1'b0}};
            last_period <= per_meas;
        end else if (per_cnt != PER_MAX) begin
            per_cnt     <= per_cnt + CW'(1);
            last_period <= last_period;
        end else begin
            per_cnt     <= per_cnt;
            last_period <= last_period;
        end
    end

    // lock state machine; locked is registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            good_cnt <= 4'd0;
            locked   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    good_cnt <= 4'd0;
                    locked   <= 1'b0;
                    if (rise) begin
                        state <= ACQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACQ: begin
                    if (tmo) begin
                        state    <= FAULT;
                        good_cnt <= 4'd0;
                        locked   <= 1'b0;
                    end else if (rise && edge_good && (good_cnt == LOCK_W)) begin
                        state    <= LOCKED;
                        good_cnt <= good_cnt;
                        locked   <= 1'b1;
                    end else if (rise && edge_good) begin
                        state    <= ACQ;
                        good_cnt <= good_cnt + 4'd1;
                        locked   <= 1'b0;
                    end else if (rise) begin
                        state    <= ACQ;
                        good_cnt <= 4'd0;
                        locked   <= 1'b0;
                    end else begin
                        state    <= ACQ;
                        good_cnt <= good_cnt;
                        locked   <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (tmo || (rise && !edge_good)) begin
                        state    <= FAULT;
                        good_cnt <= 4'd0;
                        locked   <= 1'b0;
                    end else begin
                        state    <= LOCKED;
                        good_cnt <= good_cnt;
                        locked   <= 1'b1;
                    end
                end
                FAULT: begin
                    good_cnt <= 4'd0;
                    locked   <= 1'b0;
                    if (rise) begin
                        state <= ACQ;
                    end else begin
                        state <= FAULT;
                    end
                end
                default: begin
                    state    <= IDLE;
                    good_cnt <= 4'd0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

    // sticky period and timeout flags, a new error outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            period_err  <= per_set | (period_err & ~clr_err);
            timeout_err <= tmo | (timeout_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_odo_div_mon.sv
// Randomized bench for odo_div_mon against a history-based reference model.
// Honours ODO_MON_DUTY_CHK_EN the same way the design does.
module tb_odo_div_mon;

    localparam int D   = 9;
    localparam int LC  = 4;
    localparam int CW  = 9;
    localparam int TMO = 2 * D;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          clk_div_in = 1'b0;
    logic          clr_err    = 1'b0;
    logic          locked;
    logic          period_err;
    logic          duty_err;
    logic          timeout_err;
    logic [CW-1:0] last_period;

    int checks = 0;
    int errors = 0;

    // reference model state: input history indexed by clock edge since reset
    bit smp[$];
    int cyc    = 0;
    int lp     = 0;
    int m_mode = 0;
    int m_run  = 0;
    int m_last = 0;
    bit m_lock = 1'b0;
    bit m_pe   = 1'b0;
    bit m_de   = 1'b0;
    bit m_te   = 1'b0;

    int start_cyc   = 0;
    int lock_cyc    = -1;
    int tmo_cyc     = -1;
    bit prev_locked = 1'b0;
    bit prev_te     = 1'b0;

    always #5 clk = ~clk;

    odo_div_mon #(.DIV(D), .LOCK_CNT(LC), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_div_in  (clk_div_in),
        .clr_err     (clr_err),
        .locked      (locked),
        .period_err  (period_err),
        .duty_err    (duty_err),
        .timeout_err (timeout_err),
        .last_period (last_period)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit smp_at(input int k);
        if (k < 1 || k > smp.size()) return 1'b0;
        return smp[k-1];
    endfunction

    // model: a divided edge is seen two edges after the input is first sampled high
    always @(posedge clk or posedge rst) begin
        bit pulse, ok_p, ok_h, pe_s, de_s, te_s;
        int per, hi;
        if (rst) begin
            smp.delete();
            cyc = 0; lp = 0; m_mode = 0; m_run = 0; m_last = 0;
            m_lock = 1'b0; m_pe = 1'b0; m_de = 1'b0; m_te = 1'b0;
        end else begin
            cyc++;
            smp.push_back(clk_div_in);
            pulse = smp_at(cyc - 2) && !smp_at(cyc - 3);
            per = cyc - lp - 1;
            if (per > TMO) per = TMO;
            per = per + 1;
            pe_s = 1'b0; de_s = 1'b0; te_s = 1'b0;
            if (pulse) begin
                ok_p = (per == D);
`ifdef ODO_MON_DUTY_CHK_EN
                hi = 0;
                for (int k = lp; k < cyc; k++) if (smp_at(k - 2)) hi++;
                if (hi > TMO) hi = TMO;
                ok_h = (hi == (D - 1) / 2) || (hi == (D + 1) / 2);
`else
                ok_h = 1'b1;
`endif
                m_last = per;
                case (m_mode)
                    0: begin m_mode = 1; m_run = 0; end
                    1: begin
                        if (ok_p && ok_h) begin
                            m_run++;
                            if (m_run > LC) m_mode = 2;
                        end else begin
                            m_run = 0; pe_s = !ok_p; de_s = !ok_h;
                        end
                    end
                    2: begin
                        if (!(ok_p && ok_h)) begin
                            m_mode = 3; m_run = 0; pe_s = !ok_p; de_s = !ok_h;
                        end
                    end
                    default: begin m_mode = 1; m_run = 0; end
                endcase
                lp = cyc;
            end else if (m_mode != 0 && (cyc - lp) == TMO) begin
                te_s = 1'b1; m_mode = 3; m_run = 0;
            end
            m_pe   = pe_s | (m_pe & !clr_err);
            m_de   = de_s | (m_de & !clr_err);
            m_te   = te_s | (m_te & !clr_err);
            m_lock = (m_mode == 2);
        end
    end

    // compare every output against the model once per cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("locked", 32'(locked), 32'(m_lock));
            chk("period_err", 32'(period_err), 32'(m_pe));
            chk("duty_err", 32'(duty_err), 32'(m_de));
            chk("timeout_err", 32'(timeout_err), 32'(m_te));
            chk("last_period", 32'(last_period), 32'(m_last));
            if (locked && !prev_locked && lock_cyc < 0) lock_cyc = cyc;
            if (timeout_err && !prev_te && tmo_cyc < 0) tmo_cyc = cyc;
            prev_locked = locked;
            prev_te     = timeout_err;
        end else begin
            prev_locked = 1'b0;
            prev_te     = 1'b0;
        end
    end

    task automatic drive_period(input int len, input int hi, input int clr_at);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) start_cyc = cyc + 1;
            clk_div_in = (i < hi);
            clr_err    = (i == clr_at);
        end
    endtask

    task automatic drive_low(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_div_in = 1'b0;
            clr_err    = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_period_err"}, 32'(period_err), 32'd0);
        chk({tag, "_duty_err"}, 32'(duty_err), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_last_period"}, 32'(last_period), 32'd0);
    endtask

    initial begin
        int first;
        int s;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #2 rst = 1'b0;

        // ideal divide-by-9 from reset
        drive_low(4);
        lock_cyc = -1;
        first    = 0;
        for (int i = 0; i < 8; i++) begin
            drive_period(D, (i % 2 == 0) ? 5 : 4, -1);
            if (i == 0) first = start_cyc;
        end
        chk("lock_latency", 32'(lock_cyc - first), 32'((LC + 1) * D + 2));
        chk("ideal_locked", 32'(locked), 32'd1);
        chk("ideal_last_period", 32'(last_period), 32'd9);
        chk("ideal_period_err", 32'(period_err), 32'd0);
        chk("ideal_duty_err", 32'(duty_err), 32'd0);
        chk("ideal_timeout_err", 32'(timeout_err), 32'd0);

        // one long period while locked, then re-lock
        drive_period(10, 5, -1);
        drive_period(D, 5, -1);
        chk("long_period_err", 32'(period_err), 32'd1);
        chk("long_unlocked", 32'(locked), 32'd0);
        chk("long_last_period", 32'(last_period), 32'd10);
        for (int i = 0; i < 6; i++) drive_period(D, 5, -1);
        chk("relock", 32'(locked), 32'd1);

        // clear, then a correct period with a 2-cycle high phase
        drive_period(D, 5, 4);
        chk("cleared_period_err", 32'(period_err), 32'd0);
        drive_period(D, 2, -1);
        drive_period(D, 5, -1);
`ifdef ODO_MON_DUTY_CHK_EN
        chk("short_high_duty_err", 32'(duty_err), 32'd1);
`else
        chk("short_high_duty_err", 32'(duty_err), 32'd0);
`endif
        chk("short_high_period_err", 32'(period_err), 32'd0);

        // clear coinciding with a new period error: the error wins
        drive_period(D, 5, 4);
        chk("cleared_duty_err", 32'(duty_err), 32'd0);
        drive_period(11, 5, -1);
        drive_period(D, 5, 2);
        chk("set_beats_clear", 32'(period_err), 32'd1);
        drive_period(D, 5, 5);
        chk("clear_alone", 32'(period_err), 32'd0);

        // randomized periods, duty, clears and occasional dropouts
        for (int i = 0; i < 80; i++) begin
            int len, hi, ca, r;
            r = int'($urandom_range(0, 99));
            if (r < 60) len = D;
            else if (r < 90) len = int'($urandom_range(7, 12));
            else len = int'($urandom_range(18, 24));
            r = int'($urandom_range(0, 99));
            if (r < 70) hi = len / 2 + int'($urandom_range(0, 1));
            else hi = int'($urandom_range(1, len - 1));
            ca = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            drive_period(len, hi, ca);
        end

        // re-lock with flags cleared, then lose the divided clock
        for (int i = 0; i < 8; i++) drive_period(D, 5, (i == 2) ? 4 : -1);
        chk("pre_timeout_locked", 32'(locked), 32'd1);
        chk("pre_timeout_flag", 32'(timeout_err), 32'd0);
        drive_period(D, 5, -1);
        s       = start_cyc;
        tmo_cyc = -1;
        drive_low(25);
        chk("timeout_latency", 32'(tmo_cyc - s), 32'(TMO + 2));
        chk("timeout_flag", 32'(timeout_err), 32'd1);
        chk("timeout_unlocked", 32'(locked), 32'd0);

        // reset in the middle of a locked period
        for (int i = 0; i < 8; i++) drive_period(D, 5, -1);
        chk("pre_reset_locked", 32'(locked), 32'd1);
        @(negedge clk);
        clk_div_in = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        clk_div_in = 1'b0;
        #2 rst = 1'b0;
        drive_low(3);
        lock_cyc = -1;
        first    = 0;
        for (int i = 0; i < 8; i++) begin
            drive_period(D, 4, -1);
            if (i == 0) first = start_cyc;
        end
        chk("relock_latency", 32'(lock_cyc - first), 32'((LC + 1) * D + 2));
        chk("post_reset_locked", 32'(locked), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
